// File: rtl/colnorm_sort_permuter.sv
// Column-norm sorter / permuter.
// Captures the 8 column norms and the 8x8 real channel matrix, sorts the norms
// ascending with an odd-even transposition sort (one phase per cycle, 8 phases),
// and moves each column index and whole H column along with its norm.
// Strict compares make the sort stable: equal norms keep their original order.
module colnorm_sort_permuter #(
  parameter int unsigned N  = 8,
  parameter int unsigned WL = 16,
  parameter int unsigned CW = 24
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [N*CW-1:0]   colnorm,
  input  logic [N*N*WL-1:0] Hmatrix,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [N*3-1:0]    perm,
  output logic [N*CW-1:0]   norm_srt,
  output logic [N*N*WL-1:0] H_srt
);

  localparam int unsigned IW = 3;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SORT,
    S_DONE
  } state_t;

  typedef logic [N-1:0][IW-1:0]          idx_t;
  typedef logic [N-1:0][CW-1:0]          key_t;
  // [row][col]; matches the packing of Hmatrix ((row*N+col)*WL).
  typedef logic [N-1:0][N-1:0][WL-1:0]   mat_t;

  state_t         state_q, state_d;
  logic [2:0]     phase_q, phase_d;
  key_t           key_q, key_d;
  idx_t           idx_q, idx_d;
  mat_t           h_q, h_d;

  function automatic idx_t identity_perm();
    idx_t r;
    for (int unsigned k = 0; k < N; k++) begin
      r[k] = IW'(k);
    end
    return r;
  endfunction

  // State, phase and sort working registers (keys, indices, H columns).
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      phase_q <= '0;
      key_q   <= '0;
      idx_q   <= identity_perm();
      h_q     <= '0;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      key_q   <= key_d;
      idx_q   <= idx_d;
      h_q     <= h_d;
    end
  end

  // Next state: capture on handshake, one compare-exchange phase per SORT cycle,
  // hold the result in DONE until it is accepted.
  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    key_d   = key_q;
    idx_d   = idx_q;
    h_d     = h_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          state_d = S_SORT;
          phase_d = '0;
          key_d   = colnorm;
          h_d     = Hmatrix;
          idx_d   = identity_perm();
        end
      end
      S_SORT: begin
        // Even phases pair (0,1)(2,3).., odd phases pair (1,2)(3,4)..; pairs are
        // disjoint so every exchange reads only registered values.
        for (int unsigned k = 0; k < N - 1; k++) begin
          if ((k[0] == phase_q[0]) && (key_q[k] > key_q[k+1])) begin
            key_d[k]   = key_q[k+1];
            key_d[k+1] = key_q[k];
            idx_d[k]   = idx_q[k+1];
            idx_d[k+1] = idx_q[k];
            for (int unsigned r = 0; r < N; r++) begin
              h_d[r][k]   = h_q[r][k+1];
              h_d[r][k+1] = h_q[r][k];
            end
          end
        end
        phase_d = phase_q + 3'd1;
        if (phase_q == 3'd7) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        if (out_ready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = (state_q == S_DONE);
  assign perm      = idx_q;
  assign norm_srt  = key_q;
  assign H_srt     = h_q;

endmodule

// File: tb/tb_colnorm_sort_permuter.sv
// Self-checking bench for colnorm_sort_permuter: directed scenarios plus a
// randomized back-to-back run against a rank-based stable-sort model.
module tb_colnorm_sort_permuter;

  localparam int N  = 8;
  localparam int WL = 16;
  localparam int CW = 24;

  logic              clk = 1'b0;
  logic              rst;
  logic              in_valid;
  logic              in_ready;
  logic [N*CW-1:0]   colnorm;
  logic [N*N*WL-1:0] Hmatrix;
  logic              out_valid;
  logic              out_ready;
  logic [N*3-1:0]    perm;
  logic [N*CW-1:0]   norm_srt;
  logic [N*N*WL-1:0] H_srt;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;
  int unsigned cyc     = 0;
  int unsigned tcap    = 0;

  colnorm_sort_permuter #(.N(N), .WL(WL), .CW(CW)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .colnorm   (colnorm),
    .Hmatrix   (Hmatrix),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .perm      (perm),
    .norm_srt  (norm_srt),
    .H_srt     (H_srt)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, need finish");
    $fatal(1);
  end

  // Stable ascending sort by rank: position of column j = number of columns
  // with a smaller norm plus equal-norm columns to its left.
  task automatic model(input logic [N*CW-1:0] cn, input logic [N*N*WL-1:0] hm,
                       output logic [N*3-1:0] ep, output logic [N*CW-1:0] en,
                       output logic [N*N*WL-1:0] eh);
    int rank;
    ep = '0; en = '0; eh = '0;
    for (int j = 0; j < N; j++) begin
      rank = 0;
      for (int i = 0; i < N; i++) begin
        if ((cn[i*CW +: CW] < cn[j*CW +: CW]) ||
            ((cn[i*CW +: CW] == cn[j*CW +: CW]) && (i < j)))
          rank++;
      end
      ep[rank*3 +: 3]   = 3'(j);
      en[rank*CW +: CW] = cn[j*CW +: CW];
      for (int r = 0; r < N; r++)
        eh[(r*N+rank)*WL +: WL] = hm[(r*N+j)*WL +: WL];
    end
  endtask

  function automatic logic [N*3-1:0] id_perm();
    logic [N*3-1:0] p;
    for (int k = 0; k < N; k++) p[k*3 +: 3] = 3'(k);
    return p;
  endfunction

  task automatic rand_mat(input bit ties, output logic [N*CW-1:0] cn,
                          output logic [N*N*WL-1:0] hm);
    for (int j = 0; j < N; j++)
      cn[j*CW +: CW] = ties ? CW'($urandom_range(0, 7)) : CW'($urandom());
    for (int e = 0; e < N*N; e++)
      hm[e*WL +: WL] = WL'($urandom());
  endtask

  // Called at a negedge with in_ready high; returns just after the capture edge.
  task automatic send(input logic [N*CW-1:0] cn, input logic [N*N*WL-1:0] hm);
    colnorm  = cn;
    Hmatrix  = hm;
    in_valid = 1'b1;
    tcap     = cyc;
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  // Waits (bounded) for out_valid; lat is cycles from the capture cycle.
  task automatic wait_out(output int lat, output bit to);
    to  = 1'b0;
    lat = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (out_valid === 1'b1) begin
        lat = int'(cyc - tcap);
        return;
      end
    end
    to = 1'b1;
  endtask

  task automatic accept();
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; colnorm = '0; Hmatrix = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    n_tests++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_hs: in_ready=%b out_valid=%b, need 1 0", in_ready, out_valid);
    end
    n_tests++;
    if (perm !== id_perm() || norm_srt !== '0 || H_srt !== '0) begin
      n_fail++;
      $display("FAIL reset_data: perm=%h norm_srt=%h, need perm=%h norm_srt=0 H_srt=0",
               perm, norm_srt, id_perm());
    end
  endtask

  task automatic test_descending();
    logic [N*CW-1:0] cn; logic [N*N*WL-1:0] hm;
    logic [N*3-1:0] ep, cp; logic [N*CW-1:0] en; logic [N*N*WL-1:0] eh;
    int lat; bit to;
    rand_mat(1'b0, cn, hm);
    for (int j = 0; j < N; j++) begin
      cn[j*CW +: CW] = CW'(7 - j);
      cp[j*3 +: 3]   = 3'(7 - j);
    end
    model(cn, hm, ep, en, eh);
    send(cn, hm);
    wait_out(lat, to);
    n_tests++;
    if (to || lat != 9) begin
      n_fail++;
      $display("FAIL desc_latency: got %0d (timeout=%0d), need 9", lat, to);
    end
    n_tests++;
    if (perm !== cp || norm_srt !== en || H_srt !== eh) begin
      n_fail++;
      $display("FAIL desc_result: perm=%h norm_srt=%h, need perm=%h norm_srt=%h", perm, norm_srt, cp, en);
    end
    accept();
    n_tests++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL desc_accept: in_ready=%b out_valid=%b, need 1 0", in_ready, out_valid);
    end
  endtask

  task automatic test_equal();
    logic [N*CW-1:0] cn; logic [N*N*WL-1:0] hm;
    int lat; bit to;
    rand_mat(1'b0, cn, hm);
    for (int j = 0; j < N; j++) cn[j*CW +: CW] = CW'(16);
    send(cn, hm);
    wait_out(lat, to);
    n_tests++;
    if (to || perm !== id_perm() || norm_srt !== cn || H_srt !== hm) begin
      n_fail++;
      $display("FAIL equal_stable: perm=%h timeout=%0d, need perm=%h and H_srt==Hmatrix", perm, to, id_perm());
    end
    accept();
  endtask

  task automatic test_ties();
    logic [N*CW-1:0] cn; logic [N*N*WL-1:0] hm;
    logic [N*3-1:0] ep; logic [N*CW-1:0] en; logic [N*N*WL-1:0] eh;
    logic [N*3-1:0] cp;
    int nv[N] = '{5, 5, 1, 9, 1, 0, 9, 3};
    int pv[N] = '{5, 2, 4, 7, 0, 1, 3, 6};
    int lat; bit to;
    rand_mat(1'b0, cn, hm);
    for (int j = 0; j < N; j++) begin
      cn[j*CW +: CW] = CW'(nv[j]);
      cp[j*3 +: 3]   = 3'(pv[j]);
    end
    model(cn, hm, ep, en, eh);
    send(cn, hm);
    wait_out(lat, to);
    n_tests++;
    if (to || perm !== cp) begin
      n_fail++;
      $display("FAIL ties_perm: perm=%h timeout=%0d, need %h", perm, to, cp);
    end
    n_tests++;
    if (norm_srt !== en || H_srt !== eh) begin
      n_fail++;
      $display("FAIL ties_data: norm_srt=%h, need %h (or H_srt columns wrong)", norm_srt, en);
    end
    accept();
  endtask

  task automatic test_backpressure();
    logic [N*CW-1:0] cn, cn2; logic [N*N*WL-1:0] hm, hm2;
    logic [N*3-1:0] ep; logic [N*CW-1:0] en; logic [N*N*WL-1:0] eh;
    int lat; bit to; int bad;
    rand_mat(1'b1, cn, hm);
    model(cn, hm, ep, en, eh);
    send(cn, hm);
    wait_out(lat, to);
    n_tests++;
    if (to || lat != 9) begin
      n_fail++;
      $display("FAIL bp_latency: got %0d (timeout=%0d), need 9", lat, to);
    end
    bad = 0;
    for (int c = 0; c < 20; c++) begin
      rand_mat(1'b0, cn2, hm2);
      colnorm  = cn2;
      Hmatrix  = hm2;
      in_valid = c[0];
      @(negedge clk);
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || perm !== ep || norm_srt !== en || H_srt !== eh)
        bad++;
    end
    in_valid = 1'b0;
    n_tests++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL bp_hold: %0d unstable cycles, need 0", bad);
    end
    accept();
    n_tests++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL bp_accept: in_ready=%b out_valid=%b, need 1 0", in_ready, out_valid);
    end
    bad = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (out_valid !== 1'b0 || in_ready !== 1'b1) bad++;
    end
    n_tests++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL bp_ignored: %0d cycles with a result from ignored input, need 0", bad);
    end
  endtask

  task automatic test_reset_mid_sort();
    logic [N*CW-1:0] cn; logic [N*N*WL-1:0] hm;
    logic [N*3-1:0] ep; logic [N*CW-1:0] en; logic [N*N*WL-1:0] eh;
    int lat; bit to; int bad;
    rand_mat(1'b0, cn, hm);
    send(cn, hm);
    repeat (4) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    n_tests++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || perm !== id_perm()) begin
      n_fail++;
      $display("FAIL abort_state: in_ready=%b out_valid=%b perm=%h, need 1 0 %h",
               in_ready, out_valid, perm, id_perm());
    end
    bad = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (out_valid !== 1'b0) bad++;
    end
    n_tests++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL abort_no_output: %0d cycles with out_valid, need 0", bad);
    end
    rand_mat(1'b1, cn, hm);
    model(cn, hm, ep, en, eh);
    send(cn, hm);
    wait_out(lat, to);
    n_tests++;
    if (to || lat != 9 || perm !== ep || norm_srt !== en || H_srt !== eh) begin
      n_fail++;
      $display("FAIL abort_next: perm=%h lat=%0d timeout=%0d, need perm=%h lat=9", perm, lat, to, ep);
    end
    accept();
  endtask

  task automatic test_back_to_back();
    logic [N*CW-1:0] cn, ncn; logic [N*N*WL-1:0] hm, nhm;
    logic [N*3-1:0] ep; logic [N*CW-1:0] en; logic [N*N*WL-1:0] eh;
    int lat; bit to; bit got;
    int unsigned prev;
    rand_mat(1'b1, ncn, nhm);
    colnorm   = ncn;
    Hmatrix   = nhm;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    prev      = 0;
    for (int v = 0; v < 1000; v++) begin
      got = 1'b0;
      for (int c = 0; c < 20; c++) begin
        if (in_ready === 1'b1) begin
          got = 1'b1;
          break;
        end
        @(negedge clk);
      end
      n_tests++;
      if (!got) begin
        n_fail++;
        $display("FAIL b2b_ready: vector %0d in_ready never rose, need 1", v);
        break;
      end
      tcap = cyc;
      if (v > 0 && (tcap - prev) != 10) begin
        n_fail++;
        $display("FAIL b2b_interval: vector %0d interval %0d, need 10", v, tcap - prev);
      end
      prev = tcap;
      cn = ncn;
      hm = nhm;
      model(cn, hm, ep, en, eh);
      @(posedge clk);
      #1;
      if (v < 999) begin
        rand_mat(v[0], ncn, nhm);
        colnorm = ncn;
        Hmatrix = nhm;
      end else begin
        in_valid = 1'b0;
      end
      wait_out(lat, to);
      n_tests++;
      if (to || lat != 9 || perm !== ep || norm_srt !== en || H_srt !== eh) begin
        n_fail++;
        $display("FAIL b2b_result: vector %0d perm=%h lat=%0d timeout=%0d, need perm=%h lat=9",
                 v, perm, lat, to, ep);
      end
    end
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b0;
  endtask

  initial begin
    test_reset();
    test_descending();
    test_equal();
    test_ties();
    test_backpressure();
    test_reset_mid_sort();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
